// File: rtl/seg_serial_drv_if.sv
// rtl/seg_serial_drv_if.sv - display driver bus: divider/data inputs and serial chain outputs
interface seg_serial_drv_if;
  logic [31:0] clk_div;
  logic [31:0] data;
  logic [7:0]  dots;
  logic [7:0]  blank;
  logic        seg_sck;
  logic        seg_sdo;
  logic        seg_rck;
  logic        seg_oe_n;
  logic        busy;

  // Master drives the display content and divider, observes the chain pins
  modport master (
    output clk_div, data, dots, blank,
    input  seg_sck, seg_sdo, seg_rck, seg_oe_n, busy
  );

  // Slave is the driver block itself
  modport slave (
    input  clk_div, data, dots, blank,
    output seg_sck, seg_sdo, seg_rck, seg_oe_n, busy
  );
endinterface

// File: rtl/seg_serial_drv.sv
// rtl/seg_serial_drv.sv - 8-digit 7-segment 74HC595 serial driver; SEG_SERIAL_LZB_EN enables leading-zero blanking
module seg_serial_drv #(
  parameter int REFRESH_BIT = 19,
  parameter int SCK_BIT     = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  seg_serial_drv_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    LATCH_HI,
    LATCH_LO
  } state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [63:0] frame;
  logic [63:0] frame_next;
  logic        ref_q;
  logic        sck_q;
  logic        ref_tick;
  logic        step;
  logic        sck_r;
  logic        sdo_r;
  logic        rck_r;
  logic        oe_n_r;
  logic        busy_r;
  logic [3:0]  nib;
  logic [7:0]  seg_byte;
`ifdef SEG_SERIAL_LZB_EN
  logic        lead;
`endif

  // Only two divider bits matter; fold the rest so they are visibly consumed
  wire unused_div = ^bus.clk_div;

  // Active-low {dp,g,f,e,d,c,b,a} pattern for one hex digit, dot off
  function automatic logic [7:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 8'hC0;
      4'h1: hex7 = 8'hF9;
      4'h2: hex7 = 8'hA4;
      4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99;
      4'h5: hex7 = 8'h92;
      4'h6: hex7 = 8'h82;
      4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80;
      4'h9: hex7 = 8'h90;
      4'hA: hex7 = 8'h88;
      4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6;
      4'hD: hex7 = 8'hA1;
      4'hE: hex7 = 8'h86;
      default: hex7 = 8'h8E;
    endcase
  endfunction

  // Rising-edge detectors on the refresh and shift-step divider taps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_q <= 1'b0;
      sck_q <= 1'b0;
    end else begin
      ref_q <= bus.clk_div[REFRESH_BIT];
      sck_q <= bus.clk_div[SCK_BIT];
    end
  end

  assign ref_tick = bus.clk_div[REFRESH_BIT] & ~ref_q;
  assign step     = bus.clk_div[SCK_BIT] & ~sck_q;

  // Encode the live inputs into the 64-bit frame; only sampled in LOAD
  always_comb begin
    frame_next = '1;
    nib        = 4'h0;
    seg_byte   = 8'hFF;
`ifdef SEG_SERIAL_LZB_EN
    lead       = 1'b1;
`endif
    for (int d = 7; d >= 0; d--) begin
      nib         = bus.data[4*d +: 4];
      seg_byte    = hex7(nib);
      seg_byte[7] = ~bus.dots[d];
`ifdef SEG_SERIAL_LZB_EN
      // A lit dot counts as significant so the digit and everything below shows
      if (d != 0 && lead && nib == 4'h0 && !bus.dots[d]) begin
        seg_byte = 8'hFF;
      end
      if (nib != 4'h0 || bus.dots[d]) begin
        lead = 1'b0;
      end
`endif
      if (bus.blank[d]) begin
        seg_byte = 8'hFF;
      end
      frame_next[8*d +: 8] = seg_byte;
    end
  end

  // Frame sequencer: load, shift 64 bits MSB first, then pulse the latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 6'd0;
      frame  <= '1;
      sck_r  <= 1'b0;
      sdo_r  <= 1'b0;
      rck_r  <= 1'b0;
      oe_n_r <= 1'b1;
      busy_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ref_tick) begin
            state  <= LOAD;
            busy_r <= 1'b1;
          end
        end
        LOAD: begin
          frame <= frame_next;
          cnt   <= 6'd63;
          state <= SHIFT_LO;
        end
        SHIFT_LO: begin
          if (step) begin
            sck_r <= 1'b0;
            sdo_r <= frame[cnt];
            state <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          if (step) begin
            sck_r <= 1'b1;
            if (cnt == 6'd0) begin
              state <= LATCH_HI;
            end else begin
              cnt   <= cnt - 6'd1;
              state <= SHIFT_LO;
            end
          end
        end
        LATCH_HI: begin
          if (step) begin
            sck_r <= 1'b0;
            rck_r <= 1'b1;
            state <= LATCH_LO;
          end
        end
        LATCH_LO: begin
          if (step) begin
            rck_r  <= 1'b0;
            oe_n_r <= 1'b0;
            busy_r <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.seg_sck  = sck_r;
  assign bus.seg_sdo  = sdo_r;
  assign bus.seg_rck  = rck_r;
  assign bus.seg_oe_n = oe_n_r;
  assign bus.busy     = busy_r;

endmodule

// File: tb/tb_seg_serial_drv.sv
// tb/tb_seg_serial_drv.sv - directed self-checking bench for seg_serial_drv
module tb_seg_serial_drv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [18:0] div_cnt = '0;
  logic        ref_bit = 1'b0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  // Free-running low divider bits; the refresh tap is driven by the tests
  always @(posedge clk) div_cnt <= div_cnt + 19'd1;

  seg_serial_drv_if bus ();
  assign bus.clk_div = {12'd0, ref_bit, div_cnt};

  seg_serial_drv #(.REFRESH_BIT(19), .SCK_BIT(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // Raise the refresh tap at a fixed step phase so frame length is exactly 1041
  task automatic start_frame;
    ref_bit = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      if (div_cnt[2:0] == 3'd3) break;
      @(negedge clk);
    end
    ref_bit = 1'b1;
  endtask

  // Observe one frame from the chain's point of view
  task automatic run_frame(output logic [63:0] got, output int nbits, output int busy_cyc,
                           output int rck_pulses, output logic timeout);
    logic prev_sck;
    logic prev_rck;
    prev_sck = bus.seg_sck;
    prev_rck = bus.seg_rck;
    got = '0; nbits = 0; busy_cyc = 0; rck_pulses = 0; timeout = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.seg_sck && !prev_sck) begin
        got = {got[62:0], bus.seg_sdo};
        nbits++;
      end
      if (bus.seg_rck && !prev_rck) rck_pulses++;
      prev_sck = bus.seg_sck;
      prev_rck = bus.seg_rck;
      if (bus.busy) busy_cyc++;
      else begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus.seg_oe_n !== 1'b1) begin bad++; $display("FAIL reset_oe_n got=%b want=1", bus.seg_oe_n); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.seg_sck !== 1'b0) begin bad++; $display("FAIL reset_sck got=%b want=0", bus.seg_sck); end
    total++; if ({bus.seg_sdo, bus.seg_rck} !== 2'b00) begin bad++; $display("FAIL reset_sdo_rck got=%b want=00", {bus.seg_sdo, bus.seg_rck}); end
    rst_n = 1'b1;
    @(negedge clk);
    start_frame();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL busy_before_tick got=%b want=0", bus.busy); end
    @(negedge clk);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL busy_rise got=%b want=1", bus.busy); end
    begin
      int n;
      n = 0;
      while (bus.busy && n < 2000) begin @(negedge clk); n++; end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_drain_timeout busy=%b want=0", bus.busy); end
    end
  endtask

  task automatic test_basic;
    logic [63:0] got; int nb, bc, rp; logic to;
    logic [63:0] exp;
`ifdef SEG_SERIAL_LZB_EN
    exp = 64'hFFFF_FFFF_FFFF_FFF9;
`else
    exp = 64'hC0C0_C0C0_C0C0_C0F9;
`endif
    bus.data = 32'h0000_0001; bus.dots = 8'h00; bus.blank = 8'h00;
    start_frame();
    run_frame(got, nb, bc, rp, to);
    total++; if (got !== exp) begin bad++; $display("FAIL basic_frame got=%h want=%h", got, exp); end
    total++; if (nb !== 64) begin bad++; $display("FAIL basic_bits got=%0d want=64", nb); end
    total++; if (bc !== 1041) begin bad++; $display("FAIL basic_length got=%0d want=1041", bc); end
    total++; if (rp !== 1) begin bad++; $display("FAIL basic_rck got=%0d want=1", rp); end
    total++; if (to !== 1'b0) begin bad++; $display("FAIL basic_timeout got=%b want=0", to); end
    total++; if (bus.seg_oe_n !== 1'b0) begin bad++; $display("FAIL basic_oe_n got=%b want=0", bus.seg_oe_n); end
  endtask

  task automatic test_dots_blank;
    logic [63:0] got; int nb, bc, rp; logic to;
    bus.data = 32'h1234_ABCD; bus.dots = 8'h01; bus.blank = 8'h80;
    start_frame();
    run_frame(got, nb, bc, rp, to);
    total++; if (got !== 64'hFFA4_B099_8883_C621) begin bad++; $display("FAIL dots_blank_frame got=%h want=ffa4b0998883c621", got); end
    total++; if (nb !== 64) begin bad++; $display("FAIL dots_blank_bits got=%0d want=64", nb); end
  endtask

  task automatic test_lzb;
    logic [63:0] got; int nb, bc, rp; logic to;
    logic [63:0] exp_a, exp_b, exp_c;
`ifdef SEG_SERIAL_LZB_EN
    exp_a = 64'hFFFF_FFFF_FFF9_A4C0;
    exp_b = 64'hFFFF_FFFF_FFFF_FFC0;
    exp_c = 64'hFFFF_FF40_C0C0_C0C0;
`else
    exp_a = 64'hC0C0_C0C0_C0F9_A4C0;
    exp_b = 64'hC0C0_C0C0_C0C0_C0C0;
    exp_c = 64'hC0C0_C040_C0C0_C0C0;
`endif
    bus.data = 32'h0000_0120; bus.dots = 8'h00; bus.blank = 8'h00;
    start_frame(); run_frame(got, nb, bc, rp, to);
    total++; if (got !== exp_a) begin bad++; $display("FAIL lzb_0120 got=%h want=%h", got, exp_a); end
    bus.data = 32'h0000_0000;
    start_frame(); run_frame(got, nb, bc, rp, to);
    total++; if (got !== exp_b) begin bad++; $display("FAIL lzb_zero got=%h want=%h", got, exp_b); end
    bus.dots = 8'h10;
    start_frame(); run_frame(got, nb, bc, rp, to);
    total++; if (got !== exp_c) begin bad++; $display("FAIL lzb_dot_stop got=%h want=%h", got, exp_c); end
  endtask

  task automatic test_midframe;
    logic [63:0] got; int nb, bc, rp; logic to; int extra;
    bus.data = 32'h89AB_0567; bus.dots = 8'h00; bus.blank = 8'h00;
    start_frame();
    fork
      run_frame(got, nb, bc, rp, to);
      begin
        repeat (300) @(negedge clk);
        bus.data = 32'hFFFF_FFFF; bus.dots = 8'hFF; bus.blank = 8'hAA;
        ref_bit = 1'b0;
        repeat (20) @(negedge clk);
        ref_bit = 1'b1;
      end
    join
    total++; if (got !== 64'h8090_8883_C092_82F8) begin bad++; $display("FAIL midframe_frame got=%h want=80908883c09282f8", got); end
    total++; if (bc !== 1041) begin bad++; $display("FAIL midframe_length got=%0d want=1041", bc); end
    total++; if (rp !== 1) begin bad++; $display("FAIL midframe_rck got=%0d want=1", rp); end
    extra = 0;
    repeat (50) begin @(negedge clk); if (bus.busy) extra++; end
    total++; if (extra !== 0) begin bad++; $display("FAIL midframe_no_restart busy_cycles=%0d want=0", extra); end
  endtask

  task automatic test_reset_midframe;
    logic [63:0] got; int nb, bc, rp; logic to; int rises; logic prev;
    bus.data = 32'h1234_ABCD; bus.dots = 8'h01; bus.blank = 8'h80;
    start_frame();
    rises = 0; prev = bus.seg_sck;
    for (int i = 0; i < 2000 && rises < 30; i++) begin
      @(negedge clk);
      if (bus.seg_sck && !prev) rises++;
      prev = bus.seg_sck;
    end
    total++; if (rises !== 30) begin bad++; $display("FAIL rstmid_reach_bit30 got=%0d want=30", rises); end
    rst_n = 1'b0; ref_bit = 1'b0;
    #1;
    total++; if ({bus.seg_sck, bus.seg_sdo, bus.seg_rck} !== 3'b000) begin bad++; $display("FAIL rstmid_async_low got=%b want=000", {bus.seg_sck, bus.seg_sdo, bus.seg_rck}); end
    total++; if (bus.seg_oe_n !== 1'b1) begin bad++; $display("FAIL rstmid_oe_n got=%b want=1", bus.seg_oe_n); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", bus.busy); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    start_frame();
    run_frame(got, nb, bc, rp, to);
    total++; if (got !== 64'hFFA4_B099_8883_C621) begin bad++; $display("FAIL rstmid_next_frame got=%h want=ffa4b0998883c621", got); end
    total++; if (bc !== 1041) begin bad++; $display("FAIL rstmid_length got=%0d want=1041", bc); end
    total++; if (rp !== 1) begin bad++; $display("FAIL rstmid_rck got=%0d want=1", rp); end
    total++; if (bus.seg_oe_n !== 1'b0) begin bad++; $display("FAIL rstmid_oe_after got=%b want=0", bus.seg_oe_n); end
  endtask

  initial begin
    bus.data = 32'h0000_0001;
    bus.dots = 8'h00;
    bus.blank = 8'h00;
    test_reset();
    test_basic();
    test_dots_blank();
    test_lzb();
    test_midframe();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_serial_drv.md
# seg_serial_drv

Serial driver for the board's 8-digit seven-segment display behind a 74HC595-style shift-register chain. It consumes the free-running `clk_div` bus from the clock divider and derives two things from it: a refresh trigger and a shift-step enable. On each refresh it latches the 32-bit hex value plus dot and blank masks, encodes the 64-bit segment frame, and shifts it out MSB first. It then pulses the register latch.

## Interface
- `REFRESH_BIT`, 19: index of the `clk_div` bit whose rising edge starts a frame (~95 Hz at 100 MHz).
- `SCK_BIT`, 2: index of the `clk_div` bit whose rising edge advances one shift step (one step every 8 clk).
- `clk`  in  1  system clock, the same clock that drives the divider.
- `rst_n`  in  1  asynchronous active-low reset.
- `clk_div`  in  32  free-running divider bus.
- `data`  in  32  8 hex digits; `data[31:28]` is digit 7 (leftmost).
- `dots`  in  8  decimal point per digit; 1 = lit.
- `blank`  in  8  per-digit blank; 1 = all segments off, including the dot.
- `seg_sck`  out  1  shift clock; data is sampled by the chain on its rising edge.
- `seg_sdo`  out  1  serial data.
- `seg_rck`  out  1  storage-register latch strobe.
- `seg_oe_n`  out  1  display output enable, active low.
- `busy`  out  1  a frame is in progress.

## Operation
- Edge detect: `ref_q` and `sck_q` register `clk_div[REFRESH_BIT]` and `clk_div[SCK_BIT]`; both reset to 0.
  - `ref_tick` = bit & ~`ref_q`.
  - `step` = bit & ~`sck_q`.
  - Each is exactly one clk wide.
- FSM states: IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH_HI, LATCH_LO.
- IDLE: on `ref_tick`, go to LOAD. `ref_tick` is ignored in every other state; it is neither queued nor restarts a frame.
- LOAD (1 clk, no `step` needed):
  - Capture `data`, `dots` and `blank`.
  - Build `frame[63:0]`. Byte for digit d = `frame[8d+7:8d]` = {dp,g,f,e,d,c,b,a}, active-low (0 = lit).
  - Hex encoding, dp off: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
  - `dots[d]` clears bit 7 of the byte. `blank[d]` forces the byte to FF.
  - Bit counter = 63. Go to SHIFT_LO.
- SHIFT_LO, on `step`: `seg_sck`=0, `seg_sdo`=`frame[cnt]`, go to SHIFT_HI.
- SHIFT_HI, on `step`: `seg_sck`=1. If cnt==0, go to LATCH_HI; otherwise decrement cnt and go to SHIFT_LO.
- LATCH_HI, on `step`: `seg_sck`=0, `seg_rck`=1.
- LATCH_LO, on `step`:
  - `seg_rck`=0, `seg_oe_n`=0. `seg_oe_n` stays 0 until reset.
  - Go to IDLE.
- `busy`=1 in every state except IDLE.
- Counter is 6 bits. No wrap past 0; the SHIFT_HI exit at cnt==0 is the only path out.

## Timing
- Reset values: `seg_sck`=0, `seg_sdo`=0, `seg_rck`=0, `seg_oe_n`=1, `busy`=0. State = IDLE, cnt=0, frame=all ones.
- Reset mid-frame: all outputs return to their reset values immediately (asynchronous). The partial frame is abandoned. The next frame starts at the next `ref_tick`.
- `busy` rises 1 clk after the `ref_tick` cycle.
- Frame = 1 LOAD clk + 130 steps (128 shift + 2 latch). At defaults, step period = 8 clk, giving ~1041 clk per frame.
- `seg_sdo` is stable for one full step before and after each `seg_sck` rising edge.
- Inputs change only in LOAD; changes mid-frame do not affect the frame in flight.
- If `ref_tick` and `step` coincide in IDLE, LOAD still takes the next clk. `step` is ignored in IDLE and LOAD.
- Legal configuration: `SCK_BIT` + 9 < `REFRESH_BIT`, so a frame always completes before the next refresh. Parameters outside this range are unsupported.

## Configuration
- Macro `SEG_SERIAL_LZB_EN` controls leading-zero blanking.
- Defined: during LOAD, digits 7 down to 1 that are 0 and have no more-significant nonzero digit are forced to FF. Digit 0 is never suppressed. A lit dot on a suppressed digit stops suppression at that digit: the digit shows as 0 with its dot lit, and all lower digits display normally.
- Undefined: every digit is encoded as-is. `blank` still applies in both builds.

## Test plan
- Reset check: hold `rst_n`=0 → `seg_oe_n`=1, `busy`=0, `seg_sck`=0. Release, then first `ref_tick` → `busy`=1 on the next clk.
- Basic frame: `data`=32'h0000_0001, `dots`=0, `blank`=0, macro undefined → 64 sampled bits = C0 ×7 then F9. One `seg_rck` pulse follows, then `seg_oe_n`=0. Frame length at defaults is 1041 clk.
- Dots and blank: `data`=32'h1234_ABCD, `dots`=8'h01, `blank`=8'h80 → bytes FF A4 B0 99 88 83 C6 21.
- Leading-zero blanking, macro defined: `data`=32'h0000_0120 → FF FF FF FF FF F9 A4 C0. With `data`=0 → FF ×7 then C0.
- Refresh and input changes mid-frame: extra `ref_tick` while `busy`=1, and `data` changed mid-frame → no restart, and the frame content is unchanged.
- Reset mid-frame: assert `rst_n` at bit 30 → outputs at reset values asynchronously. A full correct frame follows the next refresh.
